// File: rtl/round_key_buffer.sv
// round_key_buffer
//
// Sequences an external AES-128 key-expansion stage through one full forward
// schedule and keeps every round key (0..NROUNDS) in a local register file so
// the cipher core can fetch them in any order, one per cycle. Reads in
// descending order serve the decryption direction.
//
// Ports
//   CLK         clock, rising edge
//   rst         synchronous active-high reset (control and read port only)
//   start       load key_in as round key 0 and run a full expansion
//   key_in      cipher key (round key 0)
//   w_in        registered round key from the expansion stage
//   count_out   round index driven into the expansion stage
//   loop_out    expansion stage enable (1 = compute, 0 = hold)
//   select_out  expansion stage direction, tied to forward schedule (0)
//   ready       all NROUNDS+1 round keys are stored
//   rd_en       read request, honoured only while ready
//   rd_idx      round key index for the read
//   rk_out      registered read data
//   rk_valid    one-cycle pulse: rk_out carries the requested key
//   rd_err      one-cycle pulse: rd_idx was beyond the last round key
module round_key_buffer #(
  parameter int NROUNDS = 10,
  parameter int KW      = 128
) (
  input  logic          CLK,
  input  logic          rst,
  input  logic          start,
  input  logic [KW-1:0] key_in,
  input  logic [KW-1:0] w_in,
  output logic [3:0]    count_out,
  output logic          loop_out,
  output logic          select_out,
  output logic          ready,
  input  logic          rd_en,
  input  logic [3:0]    rd_idx,
  output logic [KW-1:0] rk_out,
  output logic          rk_valid,
  output logic          rd_err
);

  localparam int          NKEYS = NROUNDS + 1;
  localparam logic [3:0]  LAST  = 4'(NROUNDS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DRAIN  = 2'd2,
    READY  = 2'd3
  } state_t;

  state_t        state;
  logic [KW-1:0] slot [NKEYS];

  logic          load_key;
  logic          cap_en;
  logic [3:0]    cap_idx;

  assign select_out = 1'b0;

  // A start is only accepted from IDLE or READY; reset takes precedence.
  assign load_key = !rst && start && (state == IDLE || state == READY);

  // The expansion stage output lags count_out by one register, so while
  // count_out = k the stage is presenting round key k-1. The key for the
  // final count arrives one cycle later, during DRAIN.
  always_comb begin
    cap_en  = 1'b0;
    cap_idx = 4'd0;
    if (state == EXPAND && count_out >= 4'd2) begin
      cap_en  = 1'b1;
      cap_idx = count_out - 4'd1;
    end else if (state == DRAIN) begin
      cap_en  = 1'b1;
      cap_idx = LAST;
    end
  end

  // ---- round key storage (not reset) ----
  always_ff @(posedge CLK) begin
    if (load_key) begin
      slot[0] <= key_in;
    end
    if (cap_en) begin
      slot[cap_idx] <= w_in;
    end
  end

  // ---- control FSM and registered read port ----
  always_ff @(posedge CLK) begin
    if (rst) begin
      state     <= IDLE;
      count_out <= 4'd0;
      loop_out  <= 1'b0;
      ready     <= 1'b0;
      rk_out    <= '0;
      rk_valid  <= 1'b0;
      rd_err    <= 1'b0;
    end else begin
      rk_valid <= 1'b0;
      rd_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            count_out <= 4'd1;
            loop_out  <= 1'b1;
            state     <= EXPAND;
          end
        end
        EXPAND: begin
          if (count_out == LAST) begin
            count_out <= 4'd0;
            loop_out  <= 1'b0;
            state     <= DRAIN;
          end else begin
            count_out <= count_out + 4'd1;
          end
        end
        DRAIN: begin
          count_out <= 4'd0;
          ready     <= 1'b1;
          state     <= READY;
        end
        READY: begin
          // A restart wins over a simultaneous read; the read is dropped.
          if (start) begin
            ready     <= 1'b0;
            count_out <= 4'd1;
            loop_out  <= 1'b1;
            state     <= EXPAND;
          end else if (rd_en) begin
            if (rd_idx <= LAST) begin
              rk_out   <= slot[rd_idx];
              rk_valid <= 1'b1;
            end else begin
              rk_out <= '0;
              rd_err <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_round_key_buffer.sv
module tb_round_key_buffer;

  localparam logic [127:0] KAT_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KAT_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] KAT_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  logic         CLK = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic [127:0] w_in;
  logic [3:0]   count_out;
  logic         loop_out;
  logic         select_out;
  logic         ready;
  logic         rd_en;
  logic [3:0]   rd_idx;
  logic [127:0] rk_out;
  logic         rk_valid;
  logic         rd_err;

  int total = 0;
  int bad   = 0;

  round_key_buffer #(.NROUNDS(10), .KW(128)) dut (
    .CLK        (CLK),
    .rst        (rst),
    .start      (start),
    .key_in     (key_in),
    .w_in       (w_in),
    .count_out  (count_out),
    .loop_out   (loop_out),
    .select_out (select_out),
    .ready      (ready),
    .rd_en      (rd_en),
    .rd_idx     (rd_idx),
    .rk_out     (rk_out),
    .rk_valid   (rk_valid),
    .rd_err     (rd_err)
  );

  always #5 CLK = ~CLK;

  // AES arithmetic for the key schedule
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] v);
    logic [7:0] inv;
    logic [7:0] b;
    logic [7:0] e;
    inv = 8'h01;
    b   = v;
    e   = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) inv = gmul(inv, b);
      b = gmul(b, b);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input int k);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 1; i < k; i++) r = gmul(r, 8'h02);
    return r;
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] prev, input int k);
    logic [31:0] w0, w1, w2, w3, rot, t, n0, n1, n2, n3;
    w0 = prev[127:96];
    w1 = prev[95:64];
    w2 = prev[63:32];
    w3 = prev[31:0];
    rot = {w3[23:0], w3[31:24]};
    t = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])} ^
        {rcon(k), 24'h000000};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] rand_key();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Expansion stage attached to the DUT: one registered round per enabled cycle.
  always @(posedge CLK) begin
    if (loop_out)
      w_in <= next_key((count_out == 4'd1) ? key_in : w_in, int'(count_out));
  end

  // Reference model: ph counts edges since the accepted start (-1 = none).
  int           ph = -1;
  logic [127:0] mkeys [11];
  logic [127:0] exp_rk;
  logic         exp_vld;
  logic         exp_err;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic s, input logic r, input logic re, input logic [3:0] ri);
    bit was_ready;
    rst    = r;
    start  = s;
    rd_en  = re;
    rd_idx = ri;
    @(posedge CLK);
    was_ready = (ph == 11);
    exp_vld = 1'b0;
    exp_err = 1'b0;
    if (r) begin
      ph     = -1;
      exp_rk = '0;
    end else begin
      if (s && (ph < 0 || was_ready)) begin
        ph = 0;
        mkeys[0] = key_in;
        for (int k = 1; k <= 10; k++) mkeys[k] = next_key(mkeys[k-1], k);
      end else if (ph >= 0 && ph < 11) begin
        ph++;
      end
      if (was_ready && !s && re) begin
        if (ri <= 4'd10) begin
          exp_rk  = mkeys[ri];
          exp_vld = 1'b1;
        end else begin
          exp_rk  = '0;
          exp_err = 1'b1;
        end
      end
    end
    #1;
    chk("count_out", 128'(count_out), 128'((ph >= 0 && ph <= 9) ? ph + 1 : 0));
    chk("loop_out", 128'(loop_out), 128'(ph >= 0 && ph <= 9));
    chk("select_out", 128'(select_out), 128'(0));
    chk("ready", 128'(ready), 128'(ph == 11));
    chk("rk_valid", 128'(rk_valid), 128'(exp_vld));
    chk("rd_err", 128'(rd_err), 128'(exp_err));
    chk("vld_err_excl", 128'(rk_valid & rd_err), 128'(0));
    chk("rk_out", rk_out, exp_rk);
  endtask

  task automatic run_to_ready(input string tag);
    int n;
    n = 0;
    while (!ready && n < 20) begin
      step(1'b0, 1'b0, 1'b0, 4'd0);
      n++;
    end
    chk(tag, 128'(ready), 128'(1));
  endtask

  initial begin
    int n;
    int nv;
    bit s, r, re;
    logic [3:0] ri;

    key_in = KAT_KEY;
    w_in   = '0;

    // reset overrides start and rd_en
    step(1'b1, 1'b1, 1'b1, 4'd3);
    step(1'b1, 1'b1, 1'b1, 4'd3);

    // nominal run with the known-answer key
    key_in = KAT_KEY;
    step(1'b1, 1'b0, 1'b0, 4'd0);
    n = 0;
    while (!ready && n < 20) begin
      step(1'b0, 1'b0, 1'b1, 4'd2);
      n++;
    end
    chk("ready_latency", 128'(n), 128'(11));
    step(1'b0, 1'b0, 1'b1, 4'd1);
    chk("kat_rk1", rk_out, KAT_RK1);
    step(1'b0, 1'b0, 1'b1, 4'd10);
    chk("kat_rk10", rk_out, KAT_RK10);

    // descending burst 10..0
    nv = 0;
    for (int i = 10; i >= 0; i--) begin
      step(1'b0, 1'b0, 1'b1, 4'(i));
      nv += int'(rk_valid);
    end
    chk("burst_count", 128'(nv), 128'(11));
    chk("burst_last", rk_out, KAT_KEY);

    // out-of-range indices
    step(1'b0, 1'b0, 1'b1, 4'd11);
    chk("err11", 128'({rd_err, rk_valid}), 128'(2'b10));
    chk("err11_data", rk_out, 128'(0));
    step(1'b0, 1'b0, 1'b0, 4'd0);
    step(1'b0, 1'b0, 1'b1, 4'd15);
    chk("err15", 128'({rd_err, rk_valid}), 128'(2'b10));
    chk("err15_data", rk_out, 128'(0));

    // reset in the middle of an expansion
    key_in = rand_key();
    step(1'b1, 1'b0, 1'b0, 4'd0);
    repeat (4) step(1'b0, 1'b0, 1'b1, 4'd0);
    chk("mid_cnt5", 128'(count_out), 128'(5));
    step(1'b0, 1'b1, 1'b0, 4'd0);
    chk("abort_state", 128'({count_out, loop_out, ready}), 128'(0));
    key_in = rand_key();
    step(1'b1, 1'b0, 1'b0, 4'd0);
    run_to_ready("ready_after_abort");
    for (int i = 0; i <= 10; i++) step(1'b0, 1'b0, 1'b1, 4'(i));

    // start ignored during expansion, then start+read collision in READY
    key_in = rand_key();
    step(1'b1, 1'b0, 1'b0, 4'd0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 4'd0);
    step(1'b1, 1'b0, 1'b0, 4'd0);
    run_to_ready("ready_after_ignored_start");
    key_in = rand_key();
    step(1'b1, 1'b0, 1'b1, 4'd3);
    chk("collide", 128'({ready, rk_valid}), 128'(0));
    run_to_ready("ready_after_collide");
    for (int i = 10; i >= 0; i--) step(1'b0, 1'b0, 1'b1, 4'(i));

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      r  = ($urandom_range(0, 99) == 0);
      s  = ($urandom_range(0, 24) == 0);
      re = 1'($urandom_range(0, 1));
      ri = 4'($urandom_range(0, 15));
      if (s && !r && (ph < 0 || ph == 11)) key_in = rand_key();
      step(s, r, re, ri);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
